rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (write-enable / Rd / WriteData) between two writeback sources: the ALU result path and the load/memory path.
- Round-robin arbitration with valid/ready handshakes.
- Registered output stage drives the register file.
- Per-register pending-write scoreboard (busy_vec) that decode uses to stall on RAW hazards against in-flight writebacks.

Parameters:
- XLEN, 32, data width of register write data.
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, register index width (log2 NREG).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU writeback request.
- alu_ready  output  1  ALU request accepted this cycle.
- alu_rd  input  AW  ALU destination register.
- alu_data  input  XLEN  ALU result.
- mem_valid  input  1  load writeback request.
- mem_ready  output  1  load request accepted this cycle.
- mem_rd  input  AW  load destination register.
- mem_data  input  XLEN  load data.
- rf_we  output  1  register-file write enable.
- rf_rd  output  AW  register-file write index.
- rf_wdata  output  XLEN  register-file write data.
- reserve_valid  input  1  decode marks a destination as pending.
- reserve_rd  input  AW  register being reserved.
- busy_vec  output  NREG  bit i set = write to register i outstanding.

Behaviour:
- Reset (synchronous, active-high, clocked on clk):
  - rf_we=0, rf_rd=0, rf_wdata=0, busy_vec=0.
  - last_grant=MEM, so the first tie goes to ALU.
  - alu_ready=mem_ready=0 while reset is high.
  - Reset mid-operation discards any staged write: rf_we=0 the cycle after reset is sampled.
- Grant (combinational, from current valids and last_grant):
  - Only one valid: that source is granted.
  - Both valid: the source NOT equal to last_grant is granted.
  - Neither valid: no grant.
  - Exactly one of alu_ready/mem_ready is high per cycle at most; ready never depends on the requester's own ready.
- Handshake:
  - A transfer occurs when valid&ready are both high.
  - Requesters hold valid, rd and data stable until ready; the arbiter never requires valid to drop.
  - The losing source stalls with ready=0.
  - last_grant updates to the transferring source on every transfer.
- Output stage (1-cycle latency):
  - Transfer in cycle N: in cycle N+1, rf_rd/rf_wdata = the captured rd/data, and rf_we=1 unless rd==0.
  - A write to rd==0 completes the handshake but rf_we stays 0.
  - No transfer: rf_we=0; rf_rd/rf_wdata hold their last values.
  - Back-to-back transfers give rf_we=1 on consecutive cycles (throughput 1 write/cycle).
- Scoreboard:
  - reserve_valid with reserve_rd!=0 sets busy_vec[reserve_rd] at the next edge.
  - A cycle with rf_we=1 clears busy_vec[rf_rd] at its closing edge, the same edge the register file commits.
  - Set and clear to the same index in the same cycle: set wins (a new producer supersedes).
  - Reserving an already-busy register leaves it set.
  - busy_vec[0] is constantly 0.
  - Clears of non-busy bits are harmless.
- Starvation: with both sources continuously valid, grants strictly alternate ALU, MEM, ALU, ...

Test Plan:
- Reset, then alu_valid=1 rd=5 data=0xDEADBEEF, mem_valid=0 -> alu_ready=1 same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; then rf_we=0.
- Both valid from reset with alu rd=3 data=0x11, mem rd=4 data=0x22, held until accepted -> ALU granted first, MEM second; rf writes (3,0x11) then (4,0x22) on consecutive cycles.
- Both held valid 6 cycles with new data per transfer -> grants alternate ALU/MEM/ALU/MEM/ALU/MEM; the losing source sees ready=0 each cycle.
- reserve rd=7, then 3 cycles later mem writeback rd=7 -> busy_vec[7]=1 from the cycle after reserve until the edge ending the rf_we cycle; 0 afterwards.
- In the rf_we cycle for rd=9, also reserve_rd=9 -> busy_vec[9] remains 1; reserve_rd=0 -> busy_vec unchanged, bit0=0.
- alu writeback rd=0 data=0x55 -> alu_ready=1, rf_we stays 0. Separately, assert reset in the cycle after a transfer -> rf_we=0, busy_vec=0 next cycle.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and load
// writeback paths, with a registered write stage and a per-register pending-write scoreboard.
module rf_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    input  logic            reserve_valid,
    input  logic [AW-1:0]   reserve_rd,
    output logic [NREG-1:0] busy_vec
);

    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_t;

    src_t            last_grant;
    logic            alu_gnt;
    logic            mem_gnt;
    logic [NREG-1:0] busy_nxt;

    // On a tie the source that did not win last time is granted.
    always_comb begin
        alu_gnt = !reset && alu_valid && (!mem_valid || (last_grant == SRC_MEM));
        mem_gnt = !reset && mem_valid && (!alu_valid || (last_grant == SRC_ALU));
    end

    assign alu_ready = alu_gnt;
    assign mem_ready = mem_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= SRC_MEM;
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_wdata   <= '0;
        end else if (alu_gnt) begin
            last_grant <= SRC_ALU;
            rf_we      <= (alu_rd != '0);
            rf_rd      <= alu_rd;
            rf_wdata   <= alu_data;
        end else if (mem_gnt) begin
            last_grant <= SRC_MEM;
            rf_we      <= (mem_rd != '0);
            rf_rd      <= mem_rd;
            rf_wdata   <= mem_data;
        end else begin
            rf_we      <= 1'b0;
        end
    end

    // A reservation landing on the committing register wins: it belongs to a newer producer.
    always_comb begin
        busy_nxt = '0;
        for (int i = 1; i < NREG; i++) begin
            busy_nxt[i] = (busy_vec[i] && !(rf_we && (rf_rd == AW'(i))))
                        || (reserve_valid && (reserve_rd == AW'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and randomized checks of rf_wb_arbiter against a behavioural model of the
// grant, write-stage and scoreboard rules.
module tb_rf_wb_arbiter;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid, mem_valid, reserve_valid;
    logic            alu_ready, mem_ready, rf_we;
    logic [AW-1:0]   alu_rd, mem_rd, reserve_rd, rf_rd;
    logic [XLEN-1:0] alu_data, mem_data, rf_wdata;
    logic [NREG-1:0] busy_vec;

    rf_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .reserve_valid(reserve_valid), .reserve_rd(reserve_rd), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passes = 0;
    int fails = 0;

    // Reference state: who won last, what the write port shows, which registers are pending.
    bit              m_last_was_mem;
    bit              m_we;
    logic [AW-1:0]   m_rd;
    logic [XLEN-1:0] m_wdata;
    bit   [NREG-1:0] m_busy;
    bit              g_alu, g_mem;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        bit [NREG-1:0] nb;
        @(negedge clk);
        if (reset) begin
            g_alu = 0;
            g_mem = 0;
        end else if (alu_valid && mem_valid) begin
            g_alu = m_last_was_mem;
            g_mem = !m_last_was_mem;
        end else begin
            g_alu = alu_valid;
            g_mem = mem_valid;
        end
        check("alu_ready", alu_ready, g_alu);
        check("mem_ready", mem_ready, g_mem);
        check("rf_we", rf_we, m_we);
        check("rf_rd", rf_rd, m_rd);
        check("rf_wdata", rf_wdata, m_wdata);
        check("busy_vec", busy_vec, m_busy);
        if (reset) begin
            m_last_was_mem = 1;
            m_we = 0; m_rd = '0; m_wdata = '0; m_busy = '0;
        end else begin
            nb = m_busy;
            if (m_we) nb[m_rd] = 1'b0;
            if (reserve_valid && reserve_rd != 0) nb[reserve_rd] = 1'b1;
            m_busy = nb;
            if (g_alu) begin
                m_we = (alu_rd != 0); m_rd = alu_rd; m_wdata = alu_data; m_last_was_mem = 0;
            end else if (g_mem) begin
                m_we = (mem_rd != 0); m_rd = mem_rd; m_wdata = mem_data; m_last_was_mem = 1;
            end else begin
                m_we = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 0; mem_valid = 0; reserve_valid = 0;
        alu_rd = '0; mem_rd = '0; reserve_rd = '0; alu_data = '0; mem_data = '0;
        m_last_was_mem = 1; m_we = 0; m_rd = '0; m_wdata = '0; m_busy = '0;
        @(posedge clk);
        #1;
        cycle();
        reset = 1'b0;

        // Single ALU writeback
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        cycle();
        alu_valid = 0;
        check("t1_we", rf_we, 1'b1);
        check("t1_rd", rf_rd, 5);
        check("t1_wdata", rf_wdata, 32'hDEADBEEF);
        cycle();
        check("t1_we_off", rf_we, 1'b0);

        // Tie straight out of reset goes to ALU, then MEM on the next cycle
        reset = 1; cycle(); reset = 0;
        alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
        mem_valid = 1; mem_rd = 4; mem_data = 32'h22;
        cycle();
        if (g_alu) alu_valid = 0;
        check("t2_first", {rf_we, rf_rd, rf_wdata}, {1'b1, 5'd3, 32'h11});
        cycle();
        mem_valid = 0;
        check("t2_second", {rf_we, rf_rd, rf_wdata}, {1'b1, 5'd4, 32'h22});

        // Continuous contention alternates
        alu_valid = 1; alu_rd = 10; alu_data = $urandom;
        mem_valid = 1; mem_rd = 20; mem_data = $urandom;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("t3_alternate", rf_rd, (k % 2 == 0) ? 10 : 20);
            check("t3_we", rf_we, 1'b1);
            if (g_alu) alu_data = $urandom;
            if (g_mem) mem_data = $urandom;
        end
        alu_valid = 0; mem_valid = 0;
        cycle();

        // Reserve r7, complete it three cycles later
        reserve_valid = 1; reserve_rd = 7;
        cycle();
        reserve_valid = 0;
        check("t4_set", busy_vec[7], 1'b1);
        cycle();
        cycle();
        mem_valid = 1; mem_rd = 7; mem_data = 32'hCAFE0007;
        cycle();
        mem_valid = 0;
        check("t4_held_in_we_cycle", busy_vec[7], 1'b1);
        cycle();
        check("t4_cleared", busy_vec[7], 1'b0);

        // Re-reservation during the committing cycle keeps the bit set
        reserve_valid = 1; reserve_rd = 9;
        cycle();
        reserve_valid = 0;
        mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
        cycle();
        mem_valid = 0;
        reserve_valid = 1; reserve_rd = 9;
        cycle();
        reserve_valid = 1; reserve_rd = 0;
        check("t5_set_wins", busy_vec[9], 1'b1);
        cycle();
        reserve_valid = 0;
        check("t5_bit0", busy_vec[0], 1'b0);
        check("t5_still_busy", busy_vec[9], 1'b1);

        // Write to r0 handshakes but never writes
        alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
        cycle();
        alu_valid = 0;
        check("t6_r0_no_we", rf_we, 1'b0);

        // Reset right after a transfer drops the staged write
        reserve_valid = 1; reserve_rd = 12;
        cycle();
        reserve_valid = 0;
        alu_valid = 1; alu_rd = 12; alu_data = 32'h1234;
        cycle();
        alu_valid = 0;
        reset = 1;
        cycle();
        reset = 0;
        check("t6_reset_we", rf_we, 1'b0);
        check("t6_reset_busy", busy_vec, '0);

        // Randomized traffic; requesters hold until accepted
        for (int n = 0; n < 400; n++) begin
            if (!alu_valid || g_alu) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd = AW'($urandom);
                alu_data = $urandom;
            end
            if (!mem_valid || g_mem) begin
                mem_valid = ($urandom_range(0, 3) != 0);
                mem_rd = AW'($urandom);
                mem_data = $urandom;
            end
            reserve_valid = ($urandom_range(0, 2) == 0);
            reserve_rd = AW'($urandom);
            reset = ($urandom_range(0, 49) == 0);
            cycle();
        end
        reset = 0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
